bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 94 +++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-requester (CPU/DMA) memory bus arbiter with burst-limited handover
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_req0/1, i_rd0/1, i_wr0/1      per-requester request and access strobes
//   i_addr0/1, i_wdata0/1           per-requester address and write data
//   o_gnt0/1, o_ack0/1              registered grants, per-cycle access acknowledge
//   o_mem_rd/wr/addr/wdata          memory strobes, address and write data
//   i_mem_rdata, o_rdata            memory read data, shared read data to requesters
//   o_err                           sticky flag: granted requester asserted rd and wr together
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin tie-break in IDLE
// (default build always favours requester 0 on a tie).
module bus_arbiter #(
  parameter int AW        = 5,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req0,
  input  logic          i_req1,
  input  logic          i_rd0,
  input  logic          i_rd1,
  input  logic          i_wr0,
  input  logic          i_wr1,
  input  logic [AW-1:0] i_addr0,
  input  logic [AW-1:0] i_addr1,
  input  logic [DW-1:0] i_wdata0,
  input  logic [DW-1:0] i_wdata1,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_gnt0,
  output logic          o_gnt1,
  output logic          o_ack0,
  output logic          o_ack1,
  output logic          o_mem_rd,
  output logic          o_mem_wr,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic [DW-1:0] o_rdata,
  output logic          o_err
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  localparam logic [3:0] MB = 4'(MAX_BURST);
  state_t     r_state, w_next;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic       r_err;
  logic       w_g0, w_g1, w_rd, w_wr, w_ack, w_hit, w_tie1;
  assign w_g0        = r_state == GNT0;
  assign w_g1        = r_state == GNT1;
  assign w_rd        = w_g0 ? i_rd0 : w_g1 ? i_rd1 : 1'b0;
  assign w_wr        = w_g0 ? i_wr0 : w_g1 ? i_wr1 : 1'b0;
  assign o_gnt0      = w_g0;
  assign o_gnt1      = w_g1;
  assign o_ack0      = w_g0 & (i_rd0 | i_wr0);
  assign o_ack1      = w_g1 & (i_rd1 | i_wr1);
  assign w_ack       = o_ack0 | o_ack1;
  // read wins when both strobes are raised; the clash is flagged in r_err
  assign o_mem_rd    = w_rd;
  assign o_mem_wr    = w_wr & ~w_rd;
  assign o_mem_addr  = w_g0 ? i_addr0 : w_g1 ? i_addr1 : '0;
  assign o_mem_wdata = w_g0 ? i_wdata0 : w_g1 ? i_wdata1 : '0;
  assign o_rdata     = i_mem_rdata;
  assign o_err       = r_err;
  // this acked access completes the burst allowance
  assign w_hit       = w_ack && (({1'b0, r_cnt} + 4'd1) >= MB);
`ifdef ARB_ROUND_ROBIN_EN
  logic r_last;
  assign w_tie1 = ~r_last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_last <= 1'b1;
    else if (w_next != r_state && w_next != IDLE) r_last <= w_next == GNT1;
`else
  assign w_tie1 = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (i_req0 & i_req1) ? (w_tie1 ? GNT1 : GNT0) : i_req0 ? GNT0 : i_req1 ? GNT1 : IDLE;
      GNT0:    w_next = !i_req0 ? IDLE : (w_hit & i_req1) ? GNT1 : GNT0;
      GNT1:    w_next = !i_req1 ? IDLE : (w_hit & i_req0) ? GNT0 : GNT1;
      default: w_next = IDLE;
    endcase
    w_cnt_nxt = (w_next != r_state) ? 3'd0 : (w_ack && {1'b0, r_cnt} < MB) ? r_cnt + 3'd1 : r_cnt;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (w_ack & w_rd & w_wr) r_err <= 1'b1;
    end
endmodule
